dbus_access_ctrl: RTL
=====================

Name: dbus_access_ctrl

Overview:
- Sits between the memory stage's combinational data-bus request and the data bus.
- Registers each request and holds it stable until the bus accepts it, then waits for the response.
- Holds the returned data until the pipeline advances M->W, and generates the memory-stall signal for the hazard unit.
- Absorbs flushes without breaking the bus protocol: an in-flight transaction always completes, and its result is discarded.

Parameters:
- TIMEOUT_CYCLES, 1024: number of consecutive cycles spent in REQ/WAIT after which bus_timeout is set; 0 disables the check.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when reset=0).
- req_in  in  dbus_req_t  request from the memory stage; already gated by upstream stall.
- page_fault  in  1  MMU fault for the current memory-stage access; a faulting request is never issued.
- flush  in  1  pipeline flush (exception or redirect) for the instruction in M.
- pipe_advance  in  1  the M->W pipeline register loads this cycle.
- dreq  out  dbus_req_t  request to the data bus.
- dresp  in  dbus_resp_t  bus response (addr_ok, data_ok, data).
- dresp_mem  out  dbus_resp_t  response presented to the memory stage.
- mem_stall  out  1  stall request to the hazard unit.
- bus_timeout  out  1  sticky error flag.

Behaviour:
- Reset state and outputs:
  - state=IDLE, kill=0, req_q='0, data_q='0, wait_cnt=0.
  - dreq='0, dresp_mem='0, mem_stall=0, bus_timeout=0.
- States: IDLE, REQ, WAIT, HOLD, encoded as a 2-bit enum. kill is a separate 1-bit flag.
- IDLE:
  - Accept when req_in.valid & ~page_fault & ~flush: req_q<=req_in, go to REQ.
  - mem_stall=1 combinationally in the accept cycle; otherwise 0.
  - dreq.valid=0.
- REQ:
  - dreq=req_q with valid=1. All fields stay stable until addr_ok.
  - addr_ok & data_ok in the same cycle: data_q<=dresp.data, go to HOLD (or to IDLE if kill).
  - addr_ok alone: go to WAIT, and dreq.valid drops next cycle.
  - mem_stall=1.
- WAIT:
  - dreq.valid=0, mem_stall=1.
  - On data_ok: data_q<=dresp.data, go to HOLD (or to IDLE if kill).
- HOLD:
  - dresp_mem.data_ok=1, dresp_mem.addr_ok=1, dresp_mem.data=data_q, mem_stall=0.
  - pipe_advance or flush: go to IDLE. A new request is not accepted in the same cycle; the earliest acceptance is the next cycle.
  - Otherwise stay in HOLD; the request is never re-issued.
- Latency:
  - req_in valid at cycle 0 -> dreq.valid at cycle 1.
  - Zero-wait bus (addr_ok & data_ok at cycle 1) -> HOLD at cycle 2 -> earliest pipe_advance at cycle 2.
  - Minimum stall: 2 cycles.
- Flush:
  - In REQ or WAIT: kill<=1; the transaction runs to data_ok and the data is discarded.
  - In IDLE: no request is accepted that cycle.
  - In HOLD: data dropped, go to IDLE.
  - kill clears on the transition to IDLE.
  - mem_stall stays 1 while killed in REQ/WAIT, so the redirected instruction waits in M.
- Stores: identical flow. data_q captures whatever the bus returns and the memory stage ignores it.
- page_fault with valid: not accepted, mem_stall=0, so the exception propagates in the same cycle.
- wait_cnt:
  - Increments every cycle in REQ/WAIT; clears on entering HOLD or IDLE; saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, bus_timeout<=1 and stays 1 until reset.
  - The FSM keeps waiting regardless.
- Asynchronous reset mid-transaction returns the block to IDLE immediately. The bus side is reset by the same signal.
- dresp_mem.data outside HOLD is '0; the memory stage must not consume it.

Decomposition:
- In the common package: dbus_access_state_t (IDLE, REQ, WAIT, HOLD). dbus_req_t and dbus_resp_t are reused unchanged.
- No sub-module: one state register, a request register, a data register, and the counter.

Test Plan:
- Zero-wait LD to 0x8000_0010 (bus returns 0xDEAD_BEEF_0000_1234 with addr_ok & data_ok at cycle 1) -> mem_stall=1 at cycles 0-1, dresp_mem.data_ok=1 with that data at cycle 2, return to IDLE after pipe_advance.
- SW with addr_ok at cycle 3 and data_ok at cycle 6 -> dreq.valid=1 at cycles 1-3 with addr/strobe 0xF0/data stable, valid=0 at cycles 4-6, HOLD at cycle 7.
- Flush at cycle 2 while in WAIT, data_ok at cycle 4 -> no HOLD state, dresp_mem.data_ok never 1, IDLE at cycle 5, kill=0.
- page_fault=1 with a valid LW -> dreq.valid stays 0, mem_stall=0 in that cycle.
- HOLD with pipe_advance held 0 for 5 cycles -> data_q stable, exactly one dreq.valid handshake is observed, and the block leaves HOLD on the first pipe_advance.
- TIMEOUT_CYCLES=8 with addr_ok never asserted -> bus_timeout=1 after 8 REQ cycles, and it stays 1 after a late addr_ok/data_ok completes.
- Reset asserted mid-REQ -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/dbus_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_access_ctrl_pkg
// Description : Shared types for the memory-stage data-bus access controller.
//               Holds the data-bus request/response structs used across the
//               core and the controller state encoding.
// Contents    : dbus_req_t          - request from M stage / to data bus
//               dbus_resp_t         - response from data bus / to M stage
//               dbus_access_state_t - IDLE, REQ, WAIT, HOLD
//               dbus_busy()         - true while a bus transaction is open
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_access_ctrl_pkg;

  localparam int DBUS_ADDR_W = 64;
  localparam int DBUS_DATA_W = 64;
  localparam int DBUS_STRB_W = DBUS_DATA_W / 8;

  // Request: for loads strobe is ignored by the bus and size selects width;
  // for stores strobe marks the written byte lanes of data.
  typedef struct packed {
    logic                   valid;
    logic [2:0]             size;
    logic [DBUS_STRB_W-1:0] strobe;
    logic [DBUS_ADDR_W-1:0] addr;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_req_t;

  // Response: addr_ok accepts the request, data_ok returns the result.
  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } dbus_access_state_t;

  // A transaction is outstanding on the bus in REQ and WAIT.
  function automatic logic dbus_busy(input dbus_access_state_t s);
    return (s == REQ) || (s == WAIT);
  endfunction

endpackage : dbus_access_ctrl_pkg
`default_nettype wire

// File: rtl/dbus_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbus_access_ctrl
// Description : Registers the memory stage's data-bus request, keeps it
//               stable on the bus until addr_ok, waits for data_ok, and
//               holds the returned data until the M->W register loads.
//               Generates mem_stall for the hazard unit. Flushes never cut
//               a bus transaction short: an open transaction is marked
//               killed, allowed to finish, and its data dropped.
// Parameters  : TIMEOUT_CYCLES - consecutive REQ/WAIT cycles before the
//                                sticky bus_timeout flag sets (0 = off)
// Ports       : clk          in   clock
//               reset        in   asynchronous reset, active low
//               req_in       in   request from the memory stage
//               page_fault   in   MMU fault for the current access
//               flush        in   flush of the instruction in M
//               pipe_advance in   M->W register loads this cycle
//               dreq         out  request to the data bus
//               dresp        in   response from the data bus
//               dresp_mem    out  response presented to the memory stage
//               mem_stall    out  stall request to the hazard unit
//               bus_timeout  out  sticky bus timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_access_ctrl
  import dbus_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  req_in,
  input  logic       page_fault,
  input  logic       flush,
  input  logic       pipe_advance,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output dbus_resp_t dresp_mem,
  output logic       mem_stall,
  output logic       bus_timeout
);

  dbus_access_state_t       state;
  dbus_access_state_t       state_next;
  logic                     kill;
  logic                     kill_next;
  dbus_req_t                req_q;
  logic [DBUS_DATA_W-1:0]   data_q;
  logic                     accept;
  logic                     capture_req;
  logic                     capture_data;
  logic                     discard;

  // A faulting or flushed request is never issued; with mem_stall low the
  // fault/flush proceeds down the pipe in the same cycle.
  assign accept  = req_in.valid & ~page_fault & ~flush;

  // A flush arriving in the completion cycle kills that transaction too.
  assign discard = kill | flush;

  // --------------------------------------------------------------------------
  // State register and transaction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      kill   <= 1'b0;
      req_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
      if (capture_req) begin
        req_q <= req_in;
      end
      // Stores land here too; the memory stage ignores the value.
      if (capture_data) begin
        data_q <= dresp.data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state, kill tracking and stall generation
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    kill_next    = kill;
    capture_req  = 1'b0;
    capture_data = 1'b0;
    mem_stall    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          capture_req = 1'b1;
          mem_stall   = 1'b1;
          state_next  = REQ;
        end
      end

      REQ: begin
        // Stall stays high while killed so the redirected instruction
        // waits in M until the bus is quiet again.
        mem_stall = 1'b1;
        if (flush) begin
          kill_next = 1'b1;
        end
        if (dresp.addr_ok) begin
          if (dresp.data_ok) begin
            capture_data = 1'b1;
            state_next   = discard ? IDLE : HOLD;
          end else begin
            state_next = WAIT;
          end
        end
      end

      WAIT: begin
        mem_stall = 1'b1;
        if (flush) begin
          kill_next = 1'b1;
        end
        if (dresp.data_ok) begin
          capture_data = 1'b1;
          state_next   = discard ? IDLE : HOLD;
        end
      end

      HOLD: begin
        // No re-accept here: the earliest new request is taken in IDLE.
        if (pipe_advance | flush) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next == IDLE) begin
      kill_next = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Bus-side and memory-stage outputs
  // --------------------------------------------------------------------------
  always_comb begin
    dreq = '0;
    if (state == REQ) begin
      dreq       = req_q;
      dreq.valid = 1'b1;
    end
  end

  always_comb begin
    dresp_mem = '0;
    if (state == HOLD) begin
      dresp_mem.addr_ok = 1'b1;
      dresp_mem.data_ok = 1'b1;
      dresp_mem.data    = data_q;
    end
  end

  // --------------------------------------------------------------------------
  // Bus timeout watchdog: counts consecutive open-transaction cycles. The FSM
  // never abandons a transaction; the flag only reports the condition.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] wait_cnt;
      logic             timeout_q;
      logic             busy;
      logic             leaving;

      assign busy    = dbus_busy(state);
      assign leaving = (state_next == IDLE) || (state_next == HOLD);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wait_cnt  <= '0;
          timeout_q <= 1'b0;
        end else begin
          if (busy && !leaving) begin
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
          end
          // Set in the same edge that brings wait_cnt to the limit.
          if (busy && ((wait_cnt == CNT_LAST) || (wait_cnt == CNT_MAX))) begin
            timeout_q <= 1'b1;
          end
        end
      end

      assign bus_timeout = timeout_q;
    end else begin : g_no_timeout
      assign bus_timeout = 1'b0;
    end
  endgenerate

endmodule : dbus_access_ctrl
`default_nettype wire
